// File: rtl/opr_sequencer.sv
// PDP-8 operate-instruction sequencer: runs group 1/2 microcoded
// ops on AC/L/PC over several cycles, one sub-step per state.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, instr        request + 12-bit operate instruction
//   ac_in, l_in, pc_in  AC, link, next PC, sampled at accept
//   sr                  switch register, sampled in OSR
//   busy, done          busy in non-IDLE states, 1-cycle done
//   ac_out,l_out,pc_out result, held until next done
//   halt, illegal       HLT executed / unsupported instruction

package opr_pkg;
   typedef logic [11:0] word;
endpackage

module opr_sequencer
   import opr_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  word  instr,
   input  word  ac_in,
   input  logic l_in,
   input  word  pc_in,
   input  word  sr,
   output logic busy,
   output logic done,
   output word  ac_out,
   output logic l_out,
   output word  pc_out,
   output logic halt,
   output logic illegal
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_CMP, S_INC, S_ROT1, S_ROT2,
      S_SKP, S_CLR2, S_OSR, S_ILL, S_DONE
   } state_t;

   state_t r_state;
   word    r_ir;
   word    r_ac;
   logic   r_l;
   word    r_pc;
   logic   r_skip;

   word    w_ac;
   logic   w_l;
   logic   w_skip;
   logic   w_orc;
   word    w_pc;
   logic   w_ill;

   // Unsupported: not an operate opcode, or group 3 (bit8 & bit0)
   assign w_ill = (instr[11:9] != 3'b111) | (instr[8] & instr[0]);
   assign w_pc  = r_pc + {11'b0, r_skip};

   always_comb begin
      w_ac   = r_ac;
      w_l    = r_l;
      w_skip = r_skip;
      w_orc  = (r_ir[6] & r_ac[11]) | (r_ir[5] & (r_ac == '0))
             | (r_ir[4] & r_l);
      unique case (r_state)
         S_CLR: begin
            if (r_ir[7]) w_ac = '0;
            if (r_ir[6]) w_l  = 1'b0;
         end
         S_CMP: begin
            if (r_ir[5]) w_ac = ~r_ac;
            if (r_ir[4]) w_l  = ~r_l;
         end
         S_INC: begin
            if (r_ir[0]) {w_l, w_ac} = {r_l, r_ac} + 13'd1;
         end
         S_ROT1: begin
            unique case (r_ir[3:1])
               3'b001:         w_ac = {r_ac[5:0], r_ac[11:6]};
               3'b010, 3'b011: {w_l, w_ac} = {r_ac, r_l};
               3'b100, 3'b101: {w_l, w_ac} = {r_ac[0], r_l, r_ac[11:1]};
               default: ;
            endcase
         end
         S_ROT2: begin
            unique case (r_ir[3:1])
               3'b011:  {w_l, w_ac} = {r_ac, r_l};
               3'b101:  {w_l, w_ac} = {r_ac[0], r_l, r_ac[11:1]};
               default: ;
            endcase
         end
         // AND group is the complement of the OR-group condition
         S_SKP:  w_skip = r_ir[3] ? ~w_orc : w_orc;
         S_CLR2: if (r_ir[7]) w_ac = '0;
         S_OSR:  if (r_ir[2]) w_ac = r_ac | sr;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
         r_ac    <= '0;
         r_l     <= 1'b0;
         r_pc    <= '0;
         r_skip  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ac_out  <= '0;
         l_out   <= 1'b0;
         pc_out  <= '0;
         halt    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         r_ac   <= w_ac;
         r_l    <= w_l;
         r_skip <= w_skip;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ir    <= instr;
                  r_ac    <= ac_in;
                  r_l     <= l_in;
                  r_pc    <= pc_in;
                  r_skip  <= 1'b0;
                  busy    <= 1'b1;
                  halt    <= 1'b0;
                  illegal <= 1'b0;
                  if (w_ill)         r_state <= S_ILL;
                  else if (!instr[8]) r_state <= S_CLR;
                  else               r_state <= S_SKP;
               end
            end
            S_CLR:  r_state <= S_CMP;
            S_CMP:  r_state <= S_INC;
            S_INC:  r_state <= S_ROT1;
            S_ROT1: r_state <= S_ROT2;
            S_SKP:  r_state <= S_CLR2;
            S_CLR2: r_state <= S_OSR;
            S_ROT2, S_OSR, S_ILL: begin
               r_state <= S_DONE;
               done    <= 1'b1;
               ac_out  <= w_ac;
               l_out   <= w_l;
               pc_out  <= w_pc;
               halt    <= (r_state == S_OSR) & r_ir[1];
               illegal <= (r_state == S_ILL);
            end
            S_DONE: begin
               r_state <= S_IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/opr_sequencer.md
OPR_SEQUENCER -- requirements
Module: opr_sequencer

Interface
REQ-001 SHALL have no parameters; all 12-bit ports use the package type word.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request to execute instr; accepted only when busy=0.
REQ-005 instr  in  12  operate instruction, bit 11 MSB (octal 7xxx).
REQ-006 ac_in, l_in, pc_in  in  12/1/12  AC, link, and PC of the next instruction; sampled at accept.
REQ-007 sr  in  12  switch register; sampled in the OSR state.
REQ-008 busy  out  1  high in every non-IDLE state.
REQ-009 done  out  1  one-cycle pulse; ac_out/l_out/pc_out/halt/illegal are valid in that cycle.
REQ-010 ac_out, l_out, pc_out  out  12/1/12  result; updated only on entry to DONE and held until the next DONE.
REQ-011 halt  out  1  HLT executed; set on entry to DONE, cleared at the next accept.
REQ-012 illegal  out  1  unsupported instruction; same set and clear timing as halt.

Function
REQ-013 Accept = start & ~busy: latch instr, ac_in, l_in, pc_in into working registers. Decode latched instr:
- instr[11:9]≠111, or instr[8]&instr[0] (group 3) -> ILL.
- instr[8]=0 -> group 1.
- otherwise -> group 2.
REQ-014 Group-1 path: CLR -> CMP -> INC -> ROT1 -> ROT2 -> DONE -> IDLE. One cycle per state; done is high in the 6th cycle after the accept edge, regardless of which bits are set.
REQ-015 CLR: bit7 CLA zeroes AC; bit6 CLL zeroes L.
REQ-016 CMP: bit5 CMA inverts AC; bit4 CML inverts L.
REQ-017 INC: bit0 IAC adds 1 to 13-bit {L,AC}, modulo 2^13 (0_7777 -> 1_0000; 1_7777 -> 0_0000).
REQ-018 Rotate select {bit3 RAR, bit2 RAL, bit1 BSW}:
- 001 BSW: ROT1 swaps AC 6-bit halves; L unchanged.
- 010 RAL: ROT1 rotates {L,AC} left 1.
- 011 RTL: ROT1 and ROT2 each rotate left 1.
- 100 RAR: ROT1 rotates right 1.
- 101 RTR: ROT1 and ROT2 each rotate right 1.
- 000, 110, 111: no change.
REQ-019 Group-2 path: SKP -> CLR2 -> OSR -> DONE -> IDLE; done is high in the 4th cycle after accept.
REQ-020 SKP: compute skip from the latched AC/L, before any clear.
- bit3=0 (OR group): skip = (bit6 & AC[11]) | (bit5 & AC==0) | (bit4 & L).
- bit3=1 (AND group): skip = (~bit6 | ~AC[11]) & (~bit5 | AC≠0) & (~bit4 | ~L); with no condition bits set this is unconditional SKP.
REQ-021 CLR2: bit7 CLA zeroes AC. OSR: bit2 ORs sr into AC. bit1 HLT sets halt at DONE.
REQ-022 ILL path: ILL -> DONE; illegal=1, AC/L unchanged, no skip; done is high in the 2nd cycle after accept.
REQ-023 pc_out = pc_in + skip, modulo 4096 (7777 -> 0000); skip=0 outside group 2.
REQ-024 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing; an accept is possible in the cycle after DONE.
REQ-025 Group-1 paths SHALL leave halt=0 and illegal=0 at DONE.

Reset
REQ-026 rst_n=0 at any edge, including mid-operation: state -> IDLE, the in-flight instruction is discarded with no done, and every output goes to 0 (ac_out, l_out, pc_out, busy, done, halt, illegal).
REQ-027 rst_n=0 SHALL override a simultaneous start.

Verification
REQ-028 7240 (CLA CMA), AC=1234, L=0 -> done at cycle 6, ac_out=7777, l_out=0, pc_out=pc_in.
REQ-029 7001 (IAC), AC=7777, L=0 -> ac_out=0000, l_out=1; 7006 (RTL), AC=4001, L=1 -> ac_out=0007, l_out=0; 7002 (BSW), AC=0123 -> ac_out=2301.
REQ-030 7440 (SZA), AC=0000, pc_in=0200 -> done at cycle 4, pc_out=0201; 7750 (SPA SNA CLA), AC=0005, pc_in=7777 -> pc_out=0000, ac_out=0000.
REQ-031 7406 (OSR HLT), AC=0070, sr=1400 -> ac_out=1470, halt=1; the next accepted instruction clears halt.
REQ-032 7401 -> illegal=1 at cycle 2, AC/L unchanged; start pulses while busy -> ignored, exactly one done per accept.
REQ-033 7001 accepted, rst_n=0 during INC -> no done pulse, all outputs 0, busy=0 on the following cycle.
